// File: rtl/td4x_pkg.sv
// Shared opcode map, FSM state encoding and instruction field helpers for td4x_core.
package td4x_pkg;

    localparam int OPC_W = 4;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;
    localparam logic [3:0] OP_HLT    = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Helpers take the instruction zero-extended to 64 bits; callers cast the imm down.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [63:0] instr);
        return instr[OPC_W-1:0];
    endfunction

    function automatic logic [63-OPC_W:0] imm_of(input logic [63:0] instr);
        return instr[63:OPC_W];
    endfunction

    // JNC looks at the carry from before this instruction clears it.
    function automatic logic jump_taken(input logic [3:0] op, input logic carry);
        return (op == OP_JMP) || ((op == OP_JNC) && !carry);
    endfunction

endpackage

// File: rtl/td4x_alu.sv
// DATA_W adder with carry-out, shared by ADD A and ADD B.
module td4x_alu #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/td4x_core.sv
// TD4-class CPU core with valid/ready fetch and a FETCH/EXEC FSM.
// Define TD4X_HALT_EN to make opcode 1000 a HLT that parks the core until reset.
module td4x_core
    import td4x_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [DATA_W+3:0] instr_i,
    output logic [PC_W-1:0]   pc_o,
    input  logic [DATA_W-1:0] in_i,
    output logic [DATA_W-1:0] out_o,
    output logic [DATA_W-1:0] reg_a_o,
    output logic [DATA_W-1:0] reg_b_o,
    output logic              carry_o,
    output logic              retire_o,
    output logic              halted_o
);

    logic [1:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic              carry_q, carry_d;
    logic [DATA_W+3:0] ir_q, ir_d;

    logic [3:0]        op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_a, alu_sum;
    logic              alu_carry;

    assign op  = opcode_of(64'(ir_q));
    assign imm = DATA_W'(imm_of(64'(ir_q)));

    assign alu_a = (op == OP_ADD_B) ? b_q : a_q;

    td4x_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i     (alu_a),
        .b_i     (imm),
        .sum_o   (alu_sum),
        .carry_o (alu_carry)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = carry_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                if (instr_valid_i) begin
                    ir_d    = instr_i;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                carry_d = 1'b0;
                pc_d    = jump_taken(op, carry_q) ? PC_W'(imm) : pc_q + PC_W'(1);
                case (op)
                    OP_ADD_A:  begin a_d = alu_sum; carry_d = alu_carry; end
                    OP_ADD_B:  begin b_d = alu_sum; carry_d = alu_carry; end
                    OP_MOV_A:  a_d = imm;
                    OP_MOV_B:  b_d = imm;
                    OP_MOV_AB: a_d = b_q;
                    OP_MOV_BA: b_d = a_q;
                    OP_IN_A:   a_d = in_i;
                    OP_IN_B:   b_d = in_i;
                    OP_OUT_B:  out_d = b_q;
                    OP_OUT_I:  out_d = imm;
`ifdef TD4X_HALT_EN
                    OP_HLT:    state_d = ST_HALT;
`endif
                    default:   ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            ir_q    <= ir_d;
        end
    end

    assign instr_ready_o = (state_q == ST_FETCH);
    assign retire_o      = (state_q == ST_EXEC);
    assign pc_o          = pc_q;
    assign out_o         = out_q;
    assign reg_a_o       = a_q;
    assign reg_b_o       = b_q;
    assign carry_o       = carry_q;
`ifdef TD4X_HALT_EN
    assign halted_o      = (state_q == ST_HALT);
`else
    assign halted_o      = 1'b0;
`endif

endmodule

// File: tb/tb_td4x_core.sv
// Scoreboard bench for td4x_core: 4-bit core driven instruction by instruction, plus an 8-bit instance.
module tb_td4x_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid_i;
    logic       instr_ready_o;
    logic [7:0] instr_i;
    logic [3:0] pc_o, in_i, out_o, reg_a_o, reg_b_o;
    logic       carry_o, retire_o, halted_o;

    logic        v8, rdy8, c8, ret8, h8;
    logic [11:0] i8;
    logic [7:0]  pc8, in8, out8, a8, b8;

    always #5 clk = ~clk;

    td4x_core #(.DATA_W(4), .PC_W(4)) dut (
        .clk(clk), .rst(rst), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_i(instr_i), .pc_o(pc_o), .in_i(in_i), .out_o(out_o), .reg_a_o(reg_a_o),
        .reg_b_o(reg_b_o), .carry_o(carry_o), .retire_o(retire_o), .halted_o(halted_o)
    );

    td4x_core #(.DATA_W(8), .PC_W(8)) dut8 (
        .clk(clk), .rst(rst), .instr_valid_i(v8), .instr_ready_o(rdy8),
        .instr_i(i8), .pc_o(pc8), .in_i(in8), .out_o(out8), .reg_a_o(a8),
        .reg_b_o(b8), .carry_o(c8), .retire_o(ret8), .halted_o(h8)
    );

    typedef struct {
        logic [3:0] pc, a, b, out;
        logic       c, h;
    } exp_t;

    exp_t sbq[$];
    logic [3:0] m_pc, m_a, m_b, m_out;
    logic       m_c, m_h;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_h = 0;
    endtask

    // Reference behaviour of one instruction at DATA_W=PC_W=4.
    task automatic model_step(input logic [3:0] op, input logic [3:0] imm, output exp_t e);
        logic [4:0] s;
        logic       jmp;
        jmp = (op == 4'hF) || (op == 4'hE && !m_c);
        m_pc = jmp ? imm : m_pc + 4'd1;
        m_c = 1'b0;
        case (op)
            4'h0: begin s = {1'b0, m_a} + {1'b0, imm}; m_a = s[3:0]; m_c = s[4]; end
            4'h5: begin s = {1'b0, m_b} + {1'b0, imm}; m_b = s[3:0]; m_c = s[4]; end
            4'h3: m_a = imm;
            4'h7: m_b = imm;
            4'h1: m_a = m_b;
            4'h4: m_b = m_a;
            4'h2: m_a = in_i;
            4'h6: m_b = in_i;
            4'h9: m_out = m_b;
            4'hB: m_out = imm;
`ifdef TD4X_HALT_EN
            4'h8: m_h = 1'b1;
`endif
            default: ;
        endcase
        e.pc = m_pc; e.a = m_a; e.b = m_b; e.out = m_out; e.c = m_c; e.h = m_h;
    endtask

    // Monitor: one negedge after a retire cycle, the architectural state must match the head entry.
    logic pend = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_pc",    32'(pc_o),    32'(e.pc));
                chk("sb_a",     32'(reg_a_o), 32'(e.a));
                chk("sb_b",     32'(reg_b_o), 32'(e.b));
                chk("sb_out",   32'(out_o),   32'(e.out));
                chk("sb_carry", 32'(carry_o), 32'(e.c));
                chk("sb_halt",  32'(halted_o), 32'(e.h));
            end
        end
        pend = retire_o && !rst;
    end

    task automatic issue(input logic [3:0] op, input logic [3:0] imm);
        exp_t e;
        int n;
        model_step(op, imm, e);
        sbq.push_back(e);
        instr_i = {imm, op};
        instr_valid_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!instr_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready_o) begin
            chk("accept_timeout", 32'd1, 32'd0);
            instr_valid_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        instr_i = {~imm, ~op};
        @(negedge clk);
        chk("retire_pulse", 32'(retire_o), 32'd1);
        chk("ready_in_exec", 32'(instr_ready_o), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] imm);
        i8 = {imm, op};
        v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        instr_valid_i = 1'b0; instr_i = '0; in_i = '0;
        v8 = 1'b0; i8 = '0; in8 = '0;
        do_reset();
        @(negedge clk);
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_retire", 32'(retire_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        @(posedge clk); #1;

        // MOV A,7; ADD A,9 overflows; JNC 5 not taken
        issue(4'h3, 4'h7);
        issue(4'h0, 4'h9);
        chk("add_a_wrap", 32'(reg_a_o), 32'd0);
        chk("add_a_carry", 32'(carry_o), 32'd1);
        issue(4'hE, 4'h5);
        chk("jnc_not_taken_pc", 32'(pc_o), 32'd3);
        chk("jnc_clears_carry", 32'(carry_o), 32'd0);

        // ADD without carry, JNC taken, JMP to max then NOP wraps
        issue(4'h0, 4'h1);
        issue(4'hE, 4'hA);
        chk("jnc_taken_pc", 32'(pc_o), 32'hA);
        issue(4'hF, 4'hF);
        issue(4'hA, 4'h3);
        chk("pc_wrap", 32'(pc_o), 32'd0);

        // Stalled fetch: nothing changes, no retire
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_retire", 32'(retire_o), 32'd0);
            chk("stall_pc", 32'(pc_o), 32'd0);
            chk("stall_a", 32'(reg_a_o), 32'(m_a));
        end
        @(posedge clk); #1;
        issue(4'h7, 4'h3);
        issue(4'h5, 4'hE);
        chk("add_b_carry", 32'(carry_o), 32'd1);

        // IN / MOV / OUT path
        in_i = 4'h6;
        issue(4'h6, 4'h0);
        in_i = 4'h9;
        issue(4'h1, 4'h0);
        issue(4'h9, 4'h0);
        chk("out_b", 32'(out_o), 32'd6);
        chk("mov_a_b", 32'(reg_a_o), 32'd6);
        issue(4'hB, 4'hC);
        chk("out_imm", 32'(out_o), 32'hC);
        issue(4'h2, 4'h0);
        issue(4'h4, 4'h0);
        chk("mov_b_a", 32'(reg_b_o), 32'h9);

        // Reset in the EXEC cycle of a pending instruction
        instr_i = 8'h53;
        instr_valid_i = 1'b1;
        @(negedge clk);
        chk("pre_rst_ready", 32'(instr_ready_o), 32'd1);
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_rst_pc", 32'(pc_o), 32'd0);
        chk("mid_rst_a", 32'(reg_a_o), 32'd0);
        chk("mid_rst_b", 32'(reg_b_o), 32'd0);
        chk("mid_rst_out", 32'(out_o), 32'd0);
        chk("mid_rst_carry", 32'(carry_o), 32'd0);
        chk("mid_rst_ready", 32'(instr_ready_o), 32'd1);
        chk("mid_rst_retire", 32'(retire_o), 32'd0);
        @(posedge clk); #1;

        issue(4'h3, 4'hF);
        issue(4'h0, 4'h1);
        issue(4'h8, 4'h0);
`ifdef TD4X_HALT_EN
        chk("hlt_halted", 32'(halted_o), 32'd1);
        chk("hlt_pc", 32'(pc_o), 32'd3);
        chk("hlt_carry", 32'(carry_o), 32'd0);
        instr_i = 8'h13;
        instr_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_ready", 32'(instr_ready_o), 32'd0);
            chk("halt_retire", 32'(retire_o), 32'd0);
        end
        instr_valid_i = 1'b0;
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("halt_rst_halted", 32'(halted_o), 32'd0);
        chk("halt_rst_pc", 32'(pc_o), 32'd0);
        chk("halt_rst_ready", 32'(instr_ready_o), 32'd1);
        @(posedge clk); #1;
`else
        chk("nop8_halted", 32'(halted_o), 32'd0);
        chk("nop8_pc", 32'(pc_o), 32'd3);
        chk("nop8_carry", 32'(carry_o), 32'd0);
        issue(4'h3, 4'h2);
        chk("nop8_runs_on", 32'(reg_a_o), 32'd2);
`endif

        // 8-bit instance: wide add overflow and wide jump target
        issue8(4'h3, 8'h01);
        issue8(4'h0, 8'hFF);
        chk("w8_add_a", 32'(a8), 32'h00);
        chk("w8_carry", 32'(c8), 32'd1);
        chk("w8_pc", 32'(pc8), 32'd2);
        issue8(4'hF, 8'hC4);
        chk("w8_jmp", 32'(pc8), 32'hC4);
        chk("w8_jmp_carry", 32'(c8), 32'd0);
        chk("w8_ready", 32'(rdy8), 32'd1);
        chk("w8_misc", 32'({h8, ret8, b8, out8}), 32'd0);

        @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
